// File: rtl/vram_arbiter.sv
// vram_arbiter: VRAM port arbiter (display > clear > CPU); display/cpu/clear request ports in, single RAM port out
module vram_arbiter #(
  parameter int HTILES = 80,
  parameter int VTILES = 60,
  parameter int CELLS = HTILES * VTILES,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [7:0]        disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              clr_start,
  input  logic [7:0]        clr_char,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [7:0] fill;
  logic g_disp, g_clr, g_cpu, disp_oor, cpu_oor, last, disp_ok, cpu_ok;
  assign disp_oor = disp_addr >= ADDR_W'(CELLS);
  assign cpu_oor = cpu_addr >= ADDR_W'(CELLS);
  assign last = cnt == ADDR_W'(CELLS - 1);
  always_comb begin
    g_disp = !rst && disp_req;
    g_clr = !rst && !disp_req && state == CLEAR;
    g_cpu = !rst && !disp_req && state == IDLE && cpu_req && !cpu_ack;
    ram_addr = g_clr ? cnt : g_cpu ? cpu_addr : disp_addr;
    ram_we = g_clr || (g_cpu && cpu_we && !cpu_oor);
    ram_wdata = g_clr ? fill : cpu_wdata;
    state_nx = (state == IDLE && clr_start) ? CLEAR : (g_clr && last) ? IDLE : state;
    cnt_nx = (state == IDLE || (g_clr && last)) ? '0 : g_clr ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      fill <= '0;
      disp_valid <= 1'b0;
      disp_ok <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_ok <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (state == IDLE && clr_start) fill <= clr_char;
      disp_valid <= g_disp;
      disp_ok <= g_disp && !disp_oor;
      cpu_ack <= g_cpu;
      cpu_ok <= g_cpu && !cpu_we && !cpu_oor;
    end
  end
  assign disp_data = disp_ok ? ram_rdata : '0;
  assign cpu_rdata = cpu_ok ? ram_rdata : '0;
  assign clr_busy = state == CLEAR;
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single port of the synchronous character video RAM (HTILES x VTILES cells, 8-bit character codes).
- Shares that port between three requesters: the display pipeline fetching the next tile, a CPU-side bus port, and an internal clear-screen sequencer.
- The display always wins, so the pixel pipeline never misses a fetch. The CPU and clear traffic fill the idle cycles between tile fetches.

Parameters:
HTILES, 80, tiles per row
VTILES, 60, tile rows
CELLS, HTILES*VTILES (4800), number of RAM cells
ADDR_W, 13, width of a linear cell address (row*HTILES+col)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
disp_req  in  1  one-cycle pulse: display needs the cell at disp_addr
disp_addr  in  ADDR_W  display cell address, valid with disp_req
disp_data  out  8  fetched character
disp_valid  out  1  one-cycle pulse; disp_data valid
cpu_req  in  1  level; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU cell address; stable while cpu_req
cpu_wdata  in  8  write data; stable while cpu_req
cpu_rdata  out  8  read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
clr_start  in  1  pulse: fill whole screen with clr_char
clr_char  in  8  fill character, sampled with clr_start
clr_busy  out  1  high while clear in progress
ram_addr  out  ADDR_W  RAM address (registered-output RAM, 1-cycle read latency)
ram_we  out  1  RAM write enable
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data, valid cycle after address

Behaviour:
- Port drive: ram_addr, ram_we and ram_wdata are combinational from the current-cycle grant. All other outputs are registered.
- Reset:
  - disp_data, disp_valid, cpu_rdata, cpu_ack, clr_busy, ram_we all 0.
  - Clear counter 0; state IDLE.
  - A reset mid-clear aborts the clear; already-written cells keep their value.
- States:
  - IDLE to CLEAR on clr_start. clr_busy goes high the cycle after clr_start; the clr_start cycle itself arbitrates as IDLE.
  - CLEAR to IDLE the cycle after the write of cell CELLS-1. clr_busy drops in that same cycle.
  - clr_start while in CLEAR is ignored; clr_char is not re-sampled.
- Per-cycle grant, fixed priority: display, then clear (CLEAR state only), then CPU (IDLE state only). Exactly one grant per cycle.
- Display grant (cycle N):
  - ram_addr=disp_addr, ram_we=0.
  - disp_valid=1 and disp_data=ram_rdata at N+1. Latency is always exactly 1.
- Clear grant:
  - ram_addr=counter, ram_we=1, ram_wdata=latched clr_char.
  - Counter increments only on granted cycles. A cycle lost to the display is a skip, not a lost cell.
- CPU grant (cycle G), only when cpu_req=1 and no ack is pending:
  - Write: RAM written at G.
  - Read: cpu_rdata=ram_rdata at G+1.
  - cpu_ack pulses at G+1 in both cases.
  - cpu_req may drop at G+1; it must not be re-granted the same request. Any request seen while cpu_ack=1 is ignored.
  - cpu_req held during CLEAR stalls, with no ack, until the clear finishes.
- Out-of-range address, cpu_addr >= CELLS: no RAM access (ram_we=0). cpu_ack still at G+1; cpu_rdata=0.
  - disp_addr >= CELLS: disp_data=0, no RAM access.
- Protocol errors: dropping cpu_req before ack is a protocol violation and has undefined effect on that transaction only.

Test Plan:
- Display fetch: reset, then disp_req with disp_addr=5 where RAM[5]=0x41 -> disp_valid one cycle later, disp_data=0x41; no other ram_we activity.
- CPU write then read:
  - cpu_req, we=1, addr=100, wdata=0x5A with no display traffic -> ram_we at grant cycle, cpu_ack next cycle.
  - Read of addr 100 -> cpu_ack with cpu_rdata=0x5A.
- Collision: cpu_req and disp_req in the same cycle -> display granted first; CPU granted next cycle; cpu_ack two cycles after request; disp_valid one cycle after request.
- Clear:
  - clr_start with clr_char=0x20, display pulsing every 8 cycles.
  - clr_busy high for CELLS plus skipped cycles; every cell reads 0x20 afterwards.
  - A pending CPU write acks only after clr_busy falls.
- Boundaries:
  - cpu_addr=4800 write -> ack, rdata=0, no RAM write.
  - clr_start during CLEAR -> no restart.
  - rst mid-clear -> clr_busy=0 next cycle; remaining cells unchanged.
